regintf_mailbox: RTL



---
 rtl/regintf_pkg.sv | 33 +++
 rtl/regintf_cmd_fifo.sv | 54 +++++
 rtl/regintf_mailbox.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/regintf_pkg.sv
// Shared register-map constants, STATUS bit positions and sticky-bit layout
// for the mailbox register interface.
package regintf_pkg;

  localparam logic [7:0] TYPE_ADDR    = 8'd0;
  localparam logic [7:0] STATUS_ADDR  = 8'd1;
  localparam logic [7:0] CONTROL_ADDR = 8'd2;

  localparam int ID_LOW_FIRST  = 4;
  localparam int ID_HIGH_FIRST = 8;
  localparam int RW_FIRST      = 16;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_RBACK_DONE = 3;
  localparam int ST_COLLISION  = 4;

  // Words 0 and 1 hold the fixed header and identity bytes.
  localparam int PROTECTED_WORDS = 2;

  // Field order mirrors STATUS[4:2] so CONTROL bits map straight onto it.
  typedef struct packed {
    logic collision;
    logic rback_done;
    logic overflow;
  } sticky_t;

  function automatic int word_idx_width(input int reg_bytes);
    return $clog2(reg_bytes / 8);
  endfunction

endpackage

// File: rtl/regintf_cmd_fifo.sv
// Synchronous command FIFO; the head entry is presented from storage so the
// output never depends combinationally on pop.
module regintf_cmd_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot the concurrent push needs, even when full.
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/regintf_mailbox.sv
// Byte-addressed register file for the serial slave front end, with a
// command-window snapshot FIFO and masked 64-bit readback writes.
module regintf_mailbox
  import regintf_pkg::*;
#(
  parameter int          REG_BYTES  = 64,
  parameter int          CMD_BASE   = 16,
  parameter int          CMD_BYTES  = 16,
  parameter int          CMD_DEPTH  = 4,
  parameter logic [7:0]  TYPE       = 8'h42,
  parameter logic [31:0] IDENT_LOW  = 32'h41424344,
  parameter logic [63:0] IDENT_HIGH = 64'h45464748494A4B4C
) (
  input  logic                                   SYS_CLK,
  input  logic                                   RST,
  input  logic [7:0]                             INDEX_POINTER,
  input  logic                                   WRITE_ENABLE,
  input  logic [7:0]                             RECEIVE_BUFFER,
  output logic [7:0]                             SEND_BUFFER,
  input  logic                                   STOP_DETECT,
  input  logic                                   DATA_VALID,
  input  logic [word_idx_width(REG_BYTES)-1:0]   DATA_OFFSET,
  input  logic [63:0]                            DATA_RBACK,
  input  logic [63:0]                            DATA_MASK,
  output logic                                   COMM_VALID,
  input  logic                                   COMM_READY,
  output logic [CMD_BYTES*8-1:0]                 COMM_DATA
);

  localparam int WORD_W = word_idx_width(REG_BYTES);
  localparam int IDX_W  = WORD_W + 3;
  localparam int CNT_W  = $clog2(CMD_DEPTH) + 1;

  logic [7:0]             mem [REG_BYTES];
  logic                   arm;
  sticky_t                sticky;
  sticky_t                sticky_set;
  sticky_t                sticky_clr;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   in_window;
  logic                   bus_write;
  logic                   rback_write;
  logic                   push;
  logic                   pop;
  logic                   abort;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [CMD_BYTES*8-1:0] snapshot;
  logic [7:0]             status;
  logic [7:0]             rd_byte;

  assign idx       = INDEX_POINTER[IDX_W-1:0];
  assign in_range  = ({1'b0, INDEX_POINTER} < 9'(REG_BYTES));
  assign in_window = ({1'b0, INDEX_POINTER} >= 9'(CMD_BASE)) &&
                     ({1'b0, INDEX_POINTER} < 9'(CMD_BASE + CMD_BYTES));
  // A readback strobe in the same cycle always wins over the bus byte.
  assign bus_write   = WRITE_ENABLE & ~DATA_VALID;
  assign rback_write = DATA_VALID & (DATA_OFFSET >= WORD_W'(PROTECTED_WORDS));
  assign push        = arm & STOP_DETECT;
  assign pop         = COMM_VALID & COMM_READY;
  assign abort       = arm & ~push & (INDEX_POINTER == TYPE_ADDR);
  assign COMM_VALID  = (fifo_count != '0);

  // Sticky set/clear requests for this cycle.
  always_comb begin
    sticky_set            = '0;
    sticky_set.overflow   = push & fifo_full & ~pop;
    sticky_set.rback_done = rback_write;
    sticky_set.collision  = DATA_VALID & WRITE_ENABLE;
    if (bus_write && (INDEX_POINTER == CONTROL_ADDR)) begin
      sticky_clr = sticky_t'(RECEIVE_BUFFER[ST_COLLISION:ST_OVERFLOW]);
    end else begin
      sticky_clr = '0;
    end
  end

  // STATUS byte assembly.
  always_comb begin
    status                              = 8'h00;
    status[ST_NOT_EMPTY]                = ~fifo_empty;
    status[ST_FULL]                     = fifo_full;
    status[ST_COLLISION:ST_OVERFLOW]    = sticky;
  end

  // Read mux over the fixed header, identity bytes and RW storage.
  always_comb begin
    rd_byte = 8'h00;
    if (!in_range) begin
      rd_byte = 8'h00;
    end else if (INDEX_POINTER == TYPE_ADDR) begin
      rd_byte = TYPE;
    end else if (INDEX_POINTER == STATUS_ADDR) begin
      rd_byte = status;
    end else if (INDEX_POINTER < 8'(ID_LOW_FIRST)) begin
      rd_byte = 8'h00;
    end else if (INDEX_POINTER < 8'(ID_HIGH_FIRST)) begin
      rd_byte = IDENT_LOW[{INDEX_POINTER[1:0], 3'b000} +: 8];
    end else if (INDEX_POINTER < 8'(RW_FIRST)) begin
      rd_byte = IDENT_HIGH[{INDEX_POINTER[2:0], 3'b000} +: 8];
    end else begin
      rd_byte = mem[idx];
    end
  end

  // Command window as it stands before this cycle's writes land.
  always_comb begin
    snapshot = '0;
    for (int i = 0; i < CMD_BYTES; i++) begin
      snapshot[8*i +: 8] = mem[CMD_BASE + i];
    end
  end

  // RW byte storage: masked readback words, then single bus bytes.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      for (int i = 0; i < REG_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (rback_write) begin
      for (int b = 0; b < 8; b++) begin
        mem[{DATA_OFFSET, 3'(b)}] <= (DATA_RBACK[8*b +: 8] & DATA_MASK[8*b +: 8]) |
                                     (mem[{DATA_OFFSET, 3'(b)}] & ~DATA_MASK[8*b +: 8]);
      end
    end else if (bus_write && in_range && (INDEX_POINTER >= 8'(RW_FIRST))) begin
      mem[idx] <= RECEIVE_BUFFER;
    end
  end

  // Arm tracks a pending command write awaiting STOP.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      arm <= 1'b0;
    end else if (WRITE_ENABLE && in_window) begin
      arm <= 1'b1;
    end else if (push || abort) begin
      arm <= 1'b0;
    end
  end

  // Sticky STATUS bits; a set in the same cycle beats a clear.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      sticky <= '0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | sticky_set;
    end
  end

  // Registered bus read byte.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      SEND_BUFFER <= 8'h00;
    end else begin
      SEND_BUFFER <= rd_byte;
    end
  end

  regintf_cmd_fifo #(
    .WIDTH (CMD_BYTES * 8),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk   (SYS_CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (snapshot),
    .rdata (COMM_DATA),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
